// File: rtl/serial_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// serial_comparator_ctrl
//
// Bit-serial unsigned magnitude comparator. On an accepted start the two
// operands are captured into shift registers. One comparator_1bit slice then
// inspects one bit pair per clock, MSB first. The gt/lt/eq verdict is
// registered and is announced with a single-cycle done pulse. This trades
// latency for area on slow control paths.
//
// Parameters
//   WIDTH       operand width in bits (>= 1)
//   EARLY_EXIT  1: stop at the first differing bit
//               0: always walk all WIDTH bits
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      synchronous reset, active-low
//   start    in   1      compare request, accepted only while idle
//   A, B     in   WIDTH  unsigned operands, sampled on the accept edge only
//   busy     out  1      high while comparing and during the done cycle
//   done     out  1      one-cycle pulse, verdict valid
//   A_gt_B   out  1      registered verdict A > B
//   A_lt_B   out  1      registered verdict A < B
//   A_eq_B   out  1      registered verdict A == B
// ---------------------------------------------------------------------------
module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);
    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);
endmodule

module serial_comparator_ctrl #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_a, shift_a_next;
    logic [WIDTH-1:0] shift_b, shift_b_next;
    logic [IDX_W-1:0] bit_idx, idx_next;
    logic             rec_gt, rec_gt_next;
    logic             rec_lt, rec_lt_next;
    logic             gt_q, gt_next;
    logic             lt_q, lt_next;
    logic             eq_q, eq_next;
    logic             bit_gt, bit_lt, bit_eq;

    // The single comparator slice always looks at the current MSB of the
    // shift registers; shifting left walks it down the operands.
    comparator_1bit u_cmp (
        .a  (shift_a[WIDTH-1]),
        .b  (shift_b[WIDTH-1]),
        .gt (bit_gt),
        .lt (bit_lt),
        .eq (bit_eq)
    );

    // State and datapath registers. Reset drops any run in progress and
    // clears the verdict; everything else just takes the computed next values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_a <= '0;
            shift_b <= '0;
            bit_idx <= '0;
            rec_gt  <= 1'b0;
            rec_lt  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state   <= state_next;
            shift_a <= shift_a_next;
            shift_b <= shift_b_next;
            bit_idx <= idx_next;
            rec_gt  <= rec_gt_next;
            rec_lt  <= rec_lt_next;
            gt_q    <= gt_next;
            lt_q    <= lt_next;
            eq_q    <= eq_next;
        end
    end

    // Next-state and datapath control. rec_gt/rec_lt remember the first
    // difference seen when the full scan is used, so later bits cannot
    // overturn a decision made at a more significant position.
    always_comb begin
        state_next   = state;
        shift_a_next = shift_a;
        shift_b_next = shift_b;
        idx_next     = bit_idx;
        rec_gt_next  = rec_gt;
        rec_lt_next  = rec_lt;
        gt_next      = gt_q;
        lt_next      = lt_q;
        eq_next      = eq_q;

        case (state)
            IDLE: begin
                if (start) begin
                    shift_a_next = A;
                    shift_b_next = B;
                    idx_next     = IDX_MSB;
                    rec_gt_next  = 1'b0;
                    rec_lt_next  = 1'b0;
                    gt_next      = 1'b0;
                    lt_next      = 1'b0;
                    eq_next      = 1'b0;
                    state_next   = COMPARE;
                end
            end

            COMPARE: begin
                if ((EARLY_EXIT != 0) && !bit_eq) begin
                    gt_next    = bit_gt;
                    lt_next    = bit_lt;
                    state_next = DONE;
                end else begin
                    if (!bit_eq && !rec_gt && !rec_lt) begin
                        rec_gt_next = bit_gt;
                        rec_lt_next = bit_lt;
                    end
                    if (bit_idx == '0) begin
                        gt_next    = rec_gt_next;
                        lt_next    = rec_lt_next;
                        eq_next    = ~(rec_gt_next | rec_lt_next);
                        state_next = DONE;
                    end else begin
                        shift_a_next = shift_a << 1;
                        shift_b_next = shift_b << 1;
                        idx_next     = bit_idx - IDX_W'(1);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign A_gt_B = gt_q;
    assign A_lt_B = lt_q;
    assign A_eq_B = eq_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_comparator_ctrl
//
// Drives an early-exit instance and a full-scan instance (both WIDTH=8) with
// the same directed operand pairs. Each request pushes the hand-computed
// verdict and done cycle for each instance into its own queue. A monitor per
// instance pops and compares whenever that instance pulses done.
// ---------------------------------------------------------------------------
module tb_serial_comparator_ctrl;

    typedef struct {
        logic [2:0] flags;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a, op_b;

    logic busy_e, done_e, gt_e, lt_e, eq_e;
    logic busy_f, done_f, gt_f, lt_f, eq_f;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0 = 0;
    exp_t exp_e[$];
    exp_t exp_f[$];
    exp_t item_e, item_f;

    serial_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .A(op_a), .B(op_b),
        .busy(busy_e), .done(done_e), .A_gt_B(gt_e), .A_lt_B(lt_e), .A_eq_B(eq_e)
    );

    serial_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start), .A(op_a), .B(op_b),
        .busy(busy_f), .done(done_f), .A_gt_B(gt_f), .A_lt_B(lt_f), .A_eq_B(eq_f)
    );

    always #5 clk = ~clk;

    // Counts rising edges; sampled on falling edges, so after edge Tn it reads n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Waits for both instances to be idle, issues a one-cycle start and
    // records the expected verdict and done cycle. exit_bit is the first
    // differing bit position, or -1 for equal operands. Operands are
    // scrambled right after the accept edge to prove they were captured.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] flags, input int exit_bit);
        int   wait_cnt;
        exp_t x;
        wait_cnt = 0;
        @(negedge clk);
        while ((busy_e || busy_f) && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (wait_cnt >= 100) checkOutput("idle_timeout", 32'd1, 32'd0);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        t0    = cyc + 1;
        x.flags = flags;
        x.cyc   = t0 + ((exit_bit >= 0) ? (8 - exit_bit) : 8);
        exp_e.push_back(x);
        x.cyc   = t0 + 8;
        exp_f.push_back(x);
        @(negedge clk);
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b ^ 8'h5A;
    endtask

    // Monitor for the early-exit instance.
    always @(negedge clk) begin
        if (done_e) begin
            if (exp_e.size() == 0) begin
                checkOutput("unexpected_done_e", 32'd1, 32'd0);
            end else begin
                item_e = exp_e.pop_front();
                checkOutput("verdict_e", {29'd0, gt_e, lt_e, eq_e}, {29'd0, item_e.flags});
                checkOutput("latency_e", cyc, item_e.cyc);
            end
        end
    end

    // Monitor for the full-scan instance.
    always @(negedge clk) begin
        if (done_f) begin
            if (exp_f.size() == 0) begin
                checkOutput("unexpected_done_f", 32'd1, 32'd0);
            end else begin
                item_f = exp_f.pop_front();
                checkOutput("verdict_f", {29'd0, gt_f, lt_f, eq_f}, {29'd0, item_f.flags});
                checkOutput("latency_f", cyc, item_f.cyc);
            end
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;

        // Reset held for two cycles, with a start request that must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("reset_e", {27'd0, busy_e, done_e, gt_e, lt_e, eq_e}, 32'd0);
        checkOutput("reset_f", {27'd0, busy_f, done_f, gt_f, lt_f, eq_f}, 32'd0);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Equal operands: nine busy cycles on both instances.
        applyStimulus(8'hA5, 8'hA5, 3'b001, -1);
        checkOutput("busy_first_f", {31'd0, busy_f}, 32'd1);
        waitUntil(t0 + 8);
        checkOutput("busy_last_f", {31'd0, busy_f}, 32'd1);
        waitUntil(t0 + 9);
        checkOutput("busy_end_f", {31'd0, busy_f}, 32'd0);
        checkOutput("busy_end_e", {31'd0, busy_e}, 32'd0);

        // MSB difference, and a first difference that later bits contradict.
        applyStimulus(8'h80, 8'h7F, 3'b100, 7);
        applyStimulus(8'h40, 8'h3F, 3'b100, 6);

        // LSB difference: flags cleared while busy, held after done.
        applyStimulus(8'h10, 8'h11, 3'b010, 0);
        checkOutput("flags_busy_e", {29'd0, gt_e, lt_e, eq_e}, 32'd0);
        checkOutput("flags_busy_f", {29'd0, gt_f, lt_f, eq_f}, 32'd0);
        waitUntil(t0 + 7);
        checkOutput("flags_busy_late_f", {29'd0, gt_f, lt_f, eq_f}, 32'd0);
        waitUntil(t0 + 11);
        checkOutput("flags_hold_e", {29'd0, gt_e, lt_e, eq_e}, 32'b010);
        checkOutput("flags_hold_f", {29'd0, gt_f, lt_f, eq_f}, 32'b010);

        // Assorted patterns, including a middle-bit exit.
        applyStimulus(8'h20, 8'h28, 3'b010, 3);
        applyStimulus(8'hFF, 8'h00, 3'b100, 7);
        applyStimulus(8'h00, 8'hFF, 3'b010, 7);
        applyStimulus(8'h01, 8'h00, 3'b100, 0);

        // Start pulses mid-run and in the done cycle, operands changed mid-run.
        applyStimulus(8'h5A, 8'h5B, 3'b010, 0);
        waitUntil(t0 + 2);
        start = 1'b1;
        op_a  = 8'hFF;
        op_b  = 8'h00;
        @(negedge clk);
        start = 1'b0;
        waitUntil(t0 + 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("ignored_start_e", {28'd0, busy_e, gt_e, lt_e, eq_e}, 32'b0010);
        checkOutput("ignored_start_f", {28'd0, busy_f, gt_f, lt_f, eq_f}, 32'b0010);

        // Reset at edge T3 abandons the run; a fresh run then completes.
        applyStimulus(8'h3C, 8'h3C, 3'b001, -1);
        waitUntil(t0 + 2);
        exp_e.delete();
        exp_f.delete();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset_e", {27'd0, busy_e, done_e, gt_e, lt_e, eq_e}, 32'd0);
        checkOutput("midrun_reset_f", {27'd0, busy_f, done_f, gt_f, lt_f, eq_f}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(8'hC3, 8'hC4, 3'b010, 2);

        // Drain outstanding expectations within a bounded window.
        k = 0;
        while ((exp_e.size() != 0 || exp_f.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        checkOutput("pending_e", exp_e.size(), 32'd0);
        checkOutput("pending_f", exp_f.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
